reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 32, bit width of each register.
REQ-002 Parameter AW, default 5, address width; register count N = 2**AW.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 A1  input  AW  read port 1 address.
REQ-006 A2  input  AW  read port 2 address.
REQ-007 RD1  output  XLEN  read port 1 data.
REQ-008 RD2  output  XLEN  read port 2 data.
REQ-009 BUSY1  output  1  pending-write flag for entry A1.
REQ-010 BUSY2  output  1  pending-write flag for entry A2.
REQ-011 A3  input  AW  write address.
REQ-012 WD3  input  XLEN  write data.
REQ-013 WE3  input  1  write enable; also retires a pending write.
REQ-014 ISS  input  1  issue strobe; marks ISS_A as pending write.
REQ-015 ISS_A  input  AW  issue destination address.
REQ-016 READY  output  1  array initialised; ports live.

Function
REQ-017 Block SHALL implement a two-state FSM, INIT and RUN; READY = 1 only in RUN.
REQ-018 INIT SHALL sweep a counter clr_ptr from 0 to N-1, writing 0 to entry clr_ptr each cycle; after writing N-1, the FSM SHALL enter RUN on the next edge (INIT lasts exactly N cycles after rst deasserts).
REQ-019 In INIT, WE3 and ISS SHALL be ignored; RD1, RD2, BUSY1 and BUSY2 SHALL be 0.
REQ-020 Reads SHALL be combinational: RDn = entry[An] in RUN.
REQ-021 Entry 0 SHALL always read 0; writes to address 0 SHALL be discarded; issue to address 0 SHALL NOT set busy.
REQ-022 In RUN, with WE3 = 1 and A3 != 0, entry[A3] SHALL take WD3 at the rising edge; the new value is visible on RDn the following cycle (REQ-031 excepted).
REQ-023 Scoreboard: one busy bit per entry; ISS = 1 SHALL set busy[ISS_A] at the edge; WE3 = 1 SHALL clear busy[A3] at the edge.
REQ-024 Simultaneous ISS and WE3 to the same address SHALL leave busy = 1 (newer producer wins).
REQ-025 Simultaneous ISS and WE3 to different addresses SHALL apply both updates.
REQ-026 BUSYn SHALL be busy[An] from the current registered state, with no look-ahead.
REQ-027 WE3 to an entry that is not busy SHALL still write the data; busy stays 0.

Reset
REQ-028 Asserting rst, including mid-INIT or mid-RUN, SHALL immediately force FSM = INIT, clr_ptr = 0, all busy bits = 0, READY = 0, and RD1/RD2/BUSY1/BUSY2 = 0.
REQ-029 Array contents SHALL NOT be reset asynchronously; the INIT sweep SHALL clear them after rst deasserts.
REQ-030 While rst = 1, the FSM SHALL hold in INIT with clr_ptr = 0.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN defined: in RUN, when WE3 = 1, A3 != 0 and A3 == An, RDn SHALL equal WD3 in the same cycle and BUSYn SHALL be 0 for that cycle.
REQ-032 Macro REGFILE_BYPASS_EN undefined: no forwarding; RDn shows the old entry value and BUSYn the registered busy bit during the write cycle.

Verification
REQ-033 Deassert rst, count cycles -> READY rises after exactly 32 cycles (AW = 5); RD1 = 0 and BUSY1 = 0 for all addresses throughout.
REQ-034 In RUN: WE3 = 1, A3 = 7, WD3 = 0xDEADBEEF, A1 = 7 -> next cycle RD1 = 0xDEADBEEF; same cycle RD1 = old value, or 0xDEADBEEF with REGFILE_BYPASS_EN defined.
REQ-035 Write 0x12345678 to A3 = 0, plus ISS with ISS_A = 0 -> RD1 (A1 = 0) = 0 and BUSY1 = 0.
REQ-036 ISS with ISS_A = 5 -> BUSY1 (A1 = 5) = 1 next cycle; WE3 with A3 = 5 -> BUSY1 = 0 next cycle; ISS and WE3 both on address 5 in the same cycle -> BUSY1 remains 1.
REQ-037 Pulse rst in RUN while busy[3] = 1 and entry 9 = 0xA5A5A5A5 -> READY = 0 and BUSY = 0 immediately; after 32 cycles READY = 1 and RD1 (A1 = 9) = 0.
REQ-038 Assert WE3 = 1 (A3 = 4, WD3 = 0x1) and ISS (ISS_A = 4) during INIT -> after READY, RD1 (A1 = 4) = 0 and BUSY1 = 0.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file with per-entry pending-write scoreboard and a power-on clearing sweep.
// Optional same-cycle write forwarding is enabled with `define REGFILE_BYPASS_EN.
module reg_file_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            BUSY1,
    output logic            BUSY2,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic            WE3,
    input  logic            ISS,
    input  logic [AW-1:0]   ISS_A,
    output logic            READY
);
    localparam int N = 2**AW;

    typedef enum logic {INIT, RUN} state_t;

    state_t          state_q;
    logic [AW-1:0]   clr_ptr_q;
    logic            ready_q;
    logic [N-1:0]    busy_q, busy_d;
    logic [XLEN-1:0] mem [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    clr_ptr_q <= clr_ptr_q + 1'b1;
                    if (clr_ptr_q == {AW{1'b1}}) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Set is applied after clear so an issue in the retiring cycle keeps the entry busy.
    always_comb begin
        busy_d = busy_q;
        if (state_q == RUN) begin
            if (WE3) busy_d[A3] = 1'b0;
            if (ISS && ISS_A != '0) busy_d[ISS_A] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    // Storage has no reset; the INIT sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (state_q == INIT)
            mem[clr_ptr_q] <= '0;
        else if (WE3 && A3 != '0)
            mem[A3] <= WD3;
    end

    always_comb begin
        RD1   = '0;
        BUSY1 = 1'b0;
        if (state_q == RUN && A1 != '0) begin
            RD1   = mem[A1];
            BUSY1 = busy_q[A1];
`ifdef REGFILE_BYPASS_EN
            if (WE3 && A3 == A1) begin
                RD1   = WD3;
                BUSY1 = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        RD2   = '0;
        BUSY2 = 1'b0;
        if (state_q == RUN && A2 != '0) begin
            RD2   = mem[A2];
            BUSY2 = busy_q[A2];
`ifdef REGFILE_BYPASS_EN
            if (WE3 && A3 == A2) begin
                RD2   = WD3;
                BUSY2 = 1'b0;
            end
`endif
        end
    end

    assign READY = ready_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: init sweep, table-driven write/issue vectors
// through a scoreboard queue, same-cycle write behaviour and reset mid-RUN / mid-INIT.
module tb_reg_file_sb;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   A1, A2, A3, ISS_A;
    logic [XLEN-1:0] RD1, RD2, WD3;
    logic            BUSY1, BUSY2, WE3, ISS, READY;

    reg_file_sb #(.XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .BUSY1(BUSY1), .BUSY2(BUSY2), .A3(A3), .WD3(WD3), .WE3(WE3),
        .ISS(ISS), .ISS_A(ISS_A), .READY(READY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;  logic [4:0] a3;    logic [31:0] wd;
        logic        iss; logic [4:0] iss_a;
        logic [4:0]  a1;  logic [31:0] rd1;  logic b1;
        logic [4:0]  a2;  logic [31:0] rd2;  logic b2;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] rd1; logic b1;
        logic [31:0] rd2; logic b2;
    } exp_t;

    vec_t tbl [10];
    exp_t sb [$];
    exp_t e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        WE3 = 1'b0; ISS = 1'b0; A3 = '0; WD3 = '0; ISS_A = '0;
    endtask

    initial begin
        // Expectations are the values seen in the cycle after each vector's edge.
        tbl[0] = '{1, 7, 32'hDEADBEEF, 0, 0,  7, 32'hDEADBEEF, 0,  5, 32'h0,        0};
        tbl[1] = '{0, 0, 32'h0,        1, 5,  5, 32'h0,        1,  7, 32'hDEADBEEF, 0};
        tbl[2] = '{1, 5, 32'h55,       0, 0,  5, 32'h55,       0,  7, 32'hDEADBEEF, 0};
        tbl[3] = '{1, 5, 32'h66,       1, 5,  5, 32'h66,       1,  0, 32'h0,        0};
        tbl[4] = '{1, 0, 32'h12345678, 1, 0,  0, 32'h0,        0,  5, 32'h66,       1};
        tbl[5] = '{1, 5, 32'h77,       1, 3,  3, 32'h0,        1,  5, 32'h77,       0};
        tbl[6] = '{0, 0, 32'h0,        0, 0,  5, 32'h77,       0,  3, 32'h0,        1};
        tbl[7] = '{1, 9, 32'hA5A5A5A5, 0, 0,  9, 32'hA5A5A5A5, 0,  3, 32'h0,        1};
        tbl[8] = '{0, 0, 32'h0,        1, 31, 31, 32'h0,       1,  9, 32'hA5A5A5A5, 0};
        tbl[9] = '{1, 31, 32'hFFFFFFFF, 0, 0, 31, 32'hFFFFFFFF, 0, 3, 32'h0,        1};

        idle(); A1 = '0; A2 = '0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, READY}, 32'd0);
        chk("reset_rd1",   RD1, 32'd0);
        chk("reset_busy1", {31'd0, BUSY1}, 32'd0);

        // Init sweep with write and issue to entry 4 that must be ignored.
        rst = 1'b0;
        WE3 = 1'b1; A3 = 5'd4; WD3 = 32'h1; ISS = 1'b1; ISS_A = 5'd4;
        cyc = 0;
        while (!READY && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (!READY) begin
                A1 = AW'(cyc);
                #1;
                chk("init_rd1",   RD1, 32'd0);
                chk("init_busy1", {31'd0, BUSY1}, 32'd0);
            end
        end
        idle();
        chk("init_len", cyc, 32);
        A1 = 5'd4; #1;
        chk("init_ignored_rd1",   RD1, 32'd0);
        chk("init_ignored_busy1", {31'd0, BUSY1}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            WE3 = tbl[i].we;  A3 = tbl[i].a3;  WD3 = tbl[i].wd;
            ISS = tbl[i].iss; ISS_A = tbl[i].iss_a;
            A1 = tbl[i].a1;   A2 = tbl[i].a2;
            sb.push_back('{i, tbl[i].rd1, tbl[i].b1, tbl[i].rd2, tbl[i].b2});
            @(posedge clk); #1;
            idle(); #1;
            e = sb.pop_front();
            chk($sformatf("vec%0d_rd1", e.idx),   RD1, e.rd1);
            chk($sformatf("vec%0d_busy1", e.idx), {31'd0, BUSY1}, {31'd0, e.b1});
            chk($sformatf("vec%0d_rd2", e.idx),   RD2, e.rd2);
            chk($sformatf("vec%0d_busy2", e.idx), {31'd0, BUSY2}, {31'd0, e.b2});
        end

        // Write to a busy entry: same-cycle view, then the next cycle.
        @(negedge clk); ISS = 1'b1; ISS_A = 5'd7; A1 = 5'd7;
        @(posedge clk); #1; idle(); #1;
        chk("iss7_busy1", {31'd0, BUSY1}, 32'd1);
        @(negedge clk); WE3 = 1'b1; A3 = 5'd7; WD3 = 32'hCAFEF00D; #1;
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle_rd1",   RD1, 32'hCAFEF00D);
        chk("same_cycle_busy1", {31'd0, BUSY1}, 32'd0);
`else
        chk("same_cycle_rd1",   RD1, 32'hDEADBEEF);
        chk("same_cycle_busy1", {31'd0, BUSY1}, 32'd1);
`endif
        @(posedge clk); #1; idle(); #1;
        chk("next_cycle_rd1",   RD1, 32'hCAFEF00D);
        chk("next_cycle_busy1", {31'd0, BUSY1}, 32'd0);

        // Reset pulse in RUN with busy[3] = 1 and entry 9 = A5A5A5A5.
        A1 = 5'd3; A2 = 5'd9; #1;
        chk("pre_rst_busy1", {31'd0, BUSY1}, 32'd1);
        chk("pre_rst_rd2",   RD2, 32'hA5A5A5A5);
        @(negedge clk); rst = 1'b1; #1;
        chk("rst_ready", {31'd0, READY}, 32'd0);
        chk("rst_busy1", {31'd0, BUSY1}, 32'd0);
        chk("rst_rd2",   RD2, 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_ready", {31'd0, READY}, 32'd0);

        // Reset again partway through INIT; the sweep must restart from zero.
        @(negedge clk); rst = 1'b0;
        repeat (10) @(posedge clk);
        #1; rst = 1'b1; #1;
        chk("mid_init_rst_ready", {31'd0, READY}, 32'd0);
        @(negedge clk); rst = 1'b0;
        cyc = 0;
        while (!READY && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reinit_len",   cyc, 32);
        chk("reinit_ready", {31'd0, READY}, 32'd1);
        chk("reinit_rd2",   RD2, 32'd0);
        chk("reinit_busy1", {31'd0, BUSY1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
